// File: rtl/music_seq_ctrl_pkg.sv
// Shared constants for the music sequencer: state codes, song length table,
// silence tone and note periods (100 MHz clock cycles per half period).
package music_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PLAY  = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

  // Song 0 is the "don't move" cue; song 3 is an unused empty slot.
  localparam int SONG_LEN [0:3] = '{112, 64, 48, 0};

  localparam int SILENCE_TONE = 50_000_000;

  localparam int CLK_HZ  = 100_000_000;
  localparam int NOTE_C4 = CLK_HZ / (2 * 262);
  localparam int NOTE_D4 = CLK_HZ / (2 * 294);
  localparam int NOTE_E4 = CLK_HZ / (2 * 330);
  localparam int NOTE_F4 = CLK_HZ / (2 * 349);
  localparam int NOTE_G4 = CLK_HZ / (2 * 392);
  localparam int NOTE_A4 = CLK_HZ / (2 * 440);
  localparam int NOTE_B4 = CLK_HZ / (2 * 494);
  localparam int NOTE_C5 = CLK_HZ / (2 * 523);

  function automatic int song_len(input logic [1:0] id);
    return SONG_LEN[id];
  endfunction

endpackage

// File: rtl/music_seq_ctrl_beat_tick_gen.sv
// Beat divider: counts 0..BEAT_DIV-1 while enabled and flags the last count.
// clr has priority over en so a restart always begins a fresh beat.
module beat_tick_gen #(
  parameter int BEAT_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = en && (div_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == LAST) div_cnt <= '0;
      else                 div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/music_seq_ctrl.sv
// Beat sequencer for the song ROMs: start/stop/pause control and beat index.
// Define MUSIC_LOOP_EN to add the loop input that wraps songs seamlessly.
module music_seq_ctrl
  import music_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000,
  parameter int BEAT_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        song_id,
  input  logic              stop,
  input  logic              pause,
`ifdef MUSIC_LOOP_EN
  input  logic              loop,
`endif
  output logic [BEAT_W-1:0] ibeatNum,
  output logic [1:0]        song_sel,
  output logic              playing,
  output logic              mute,
  output logic              done
);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_d;
  logic [1:0]        sel_d;
  logic              tick;
  logic              start_ok;
  logic              loop_now;
  logic              div_en;
  logic              div_clr;

`ifdef MUSIC_LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  // A start is ignored in FIN and for empty songs.
  assign start_ok = start && (song_len(song_id) != 0) && (state_q != ST_FIN);

  // The divider freezes on the pause cycle itself so the held count is exact.
  assign div_en  = (state_q == ST_PLAY) && !pause;
  assign div_clr = stop || start_ok;

  beat_tick_gen #(
    .BEAT_DIV(BEAT_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .clr (div_clr),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = ibeatNum;
    sel_d   = song_sel;
    if (stop) begin
      state_d = ST_IDLE;
      beat_d  = '0;
    end else if (start_ok) begin
      state_d = ST_PLAY;
      beat_d  = '0;
      sel_d   = song_id;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (int'(ibeatNum) < song_len(song_sel) - 1) beat_d = ibeatNum + BEAT_W'(1);
            else if (loop_now)                          beat_d = '0;
            else                                        state_d = ST_FIN;
          end
        end
        ST_PAUSE: if (!pause) state_d = ST_PLAY;
        ST_FIN:   state_d = ST_IDLE;
        default:  ;
      endcase
    end
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ibeatNum <= '0;
      song_sel <= 2'd0;
      playing  <= 1'b0;
      mute     <= 1'b1;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ibeatNum <= beat_d;
      song_sel <= sel_d;
      playing  <= (state_d == ST_PLAY);
      mute     <= (state_d != ST_PLAY);
      done     <= (state_d == ST_FIN);
    end
  end

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Bench for music_seq_ctrl with BEAT_DIV=4: vector table, directed corner
// sequences and random traffic against a beat/phase reference model.
module tb_music_seq_ctrl;

  localparam int DIV = 4;
  localparam int BW  = 12;
  localparam int W   = BW + 5;
  localparam int TB_LEN [0:3] = '{112, 64, 48, 0};
`ifdef MUSIC_LOOP_EN
  localparam bit LOOP_ON = 1'b1;
`else
  localparam bit LOOP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stop, pause, loop;
  logic [1:0]    song_id;
  logic [BW-1:0] ibeatNum;
  logic [1:0]    song_sel;
  logic          playing, mute, done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic loop_lvl = 1'b0;

  logic [W-1:0] exp_q[$];

  // Reference model: playback expressed as (song, beat, phase within beat).
  bit         m_run, m_paused, m_fin;
  int         m_beat, m_phase;
  logic [1:0] m_song;

  always #5 clk = ~clk;

  music_seq_ctrl #(.BEAT_DIV(DIV), .BEAT_W(BW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .song_id (song_id),
    .stop    (stop),
    .pause   (pause),
`ifdef MUSIC_LOOP_EN
    .loop    (loop),
`endif
    .ibeatNum(ibeatNum),
    .song_sel(song_sel),
    .playing (playing),
    .mute    (mute),
    .done    (done)
  );

  task automatic model_reset();
    m_run = 0; m_paused = 0; m_fin = 0; m_beat = 0; m_phase = 0; m_song = 2'd0;
  endtask

  task automatic model_step(input logic s, input logic [1:0] id, input logic st,
                            input logic p, input logic l);
    if (st) begin
      m_run = 0; m_paused = 0; m_fin = 0; m_beat = 0; m_phase = 0;
    end else if (s && !m_fin && TB_LEN[id] != 0) begin
      m_run = 1; m_paused = 0; m_beat = 0; m_phase = 0; m_song = id;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_run && m_paused) begin
      if (!p) m_paused = 0;
    end else if (m_run) begin
      if (p) begin
        m_paused = 1;
      end else if (m_phase == DIV - 1) begin
        m_phase = 0;
        if (m_beat < TB_LEN[m_song] - 1) m_beat = m_beat + 1;
        else if (l && LOOP_ON)           m_beat = 0;
        else begin
          m_run = 0; m_fin = 1;
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic pl;
    pl = m_run && !m_paused;
    return {m_fin, !pl, pl, m_song, BW'(m_beat)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive, advance model, sample 1 time unit after the edge.
  task automatic cycle(input logic s, input logic [1:0] id, input logic st,
                       input logic p, input logic l);
    logic [W-1:0] exp, act;
    start = s; song_id = id; stop = st; pause = p; loop = l;
    model_step(s, id, st, p, l);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    cyc++;
    exp = exp_q.pop_front();
    act = {done, mute, playing, song_sel, ibeatNum};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model: got done/mute/play/sel/beat=%h expected %h (cycle %0d)", act, exp, cyc);
    end
  endtask

  task automatic run_to_beat(input int b, input int budget);
    int n;
    n = 0;
    while (int'(ibeatNum) != b && n < budget) begin
      cycle(1'b0, 2'd0, 1'b0, 1'b0, loop_lvl);
      n++;
    end
    chk("reach_beat", int'(ibeatNum), b);
  endtask

  typedef struct {
    logic          s;
    logic [1:0]    id;
    logic          st;
    logic          p;
    logic [BW-1:0] beat;
    logic [1:0]    sel;
    logic          play;
    logic          mt;
    logic          dn;
  } vec_t;

  vec_t tv [11];

  initial begin
    int t_start, t_beat1, t111, tdone, dcount, n, nd, nm;
    logic pz, lp;

    tv[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 12'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{1'b1, 2'd2, 1'b0, 1'b0, 12'd0, 2'd2, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 12'd0, 2'd2, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 12'd0, 2'd2, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 12'd0, 2'd2, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 12'd1, 2'd2, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 2'd1, 1'b1, 1'b0, 12'd0, 2'd2, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 12'd0, 2'd1, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 2'd0, 1'b0, 1'b1, 12'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 2'd0, 1'b0, 1'b1, 12'd0, 2'd0, 1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 12'd0, 2'd0, 1'b0, 1'b1, 1'b0};

    // Reset held for two cycles.
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0; song_id = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_beat", int'(ibeatNum), 0);
    chk("rst_sel", int'(song_sel), 0);
    chk("rst_mute", int'(mute), 1);
    chk("rst_playing", int'(playing), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 11; i++) begin
      cycle(tv[i].s, tv[i].id, tv[i].st, tv[i].p, 1'b0);
      checks++;
      if ({ibeatNum, song_sel, playing, mute, done} !==
          {tv[i].beat, tv[i].sel, tv[i].play, tv[i].mt, tv[i].dn}) begin
        errors++;
        $display("FAIL vec%0d: got beat=%0d sel=%0d play=%0b mute=%0b done=%0b expected beat=%0d sel=%0d play=%0b mute=%0b done=%0b",
                 i, ibeatNum, song_sel, playing, mute, done,
                 tv[i].beat, tv[i].sel, tv[i].play, tv[i].mt, tv[i].dn);
      end
    end

    // Full song 0, natural end.
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    t_start = cyc; t_beat1 = -1; t111 = -1; tdone = -1; dcount = 0; n = 0;
    while (n < 600 && !(tdone >= 0 && cyc >= tdone + 2)) begin
      cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      n++;
      if (ibeatNum == 12'd1 && t_beat1 < 0) t_beat1 = cyc;
      if (ibeatNum == 12'd111 && t111 < 0) t111 = cyc;
      if (done) begin
        dcount++;
        if (tdone < 0) begin
          tdone = cyc;
          chk("fin_beat_hold", int'(ibeatNum), 111);
        end
      end
      if (tdone >= 0 && cyc == tdone + 1) begin
        chk("idle_mute", int'(mute), 1);
        chk("idle_playing", int'(playing), 0);
      end
    end
    chk("first_beat_latency", t_beat1 - t_start, DIV);
    chk("done_count", dcount, 1);
    chk("done_delay", tdone - t111, DIV);

    // Pause at beat 20 with the divider at 2.
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    run_to_beat(20, 200);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      chk("pause_beat", int'(ibeatNum), 20);
      chk("pause_mute", int'(mute), 1);
    end
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("resume_playing", int'(playing), 1);
    n = 0;
    while (ibeatNum == 12'd20 && n < 10) begin
      cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("resume_to_beat21", n, 2);
    chk("resume_beat", int'(ibeatNum), 21);

    // Stop at beat 50.
    run_to_beat(50, 200);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("stop_beat", int'(ibeatNum), 0);
    chk("stop_playing", int'(playing), 0);
    chk("stop_mute", int'(mute), 1);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      if (done) nd++;
    end
    chk("stop_no_done", nd, 0);

    // Restart at beat 30 with song 1.
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    run_to_beat(30, 200);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("restart_sel", int'(song_sel), 1);
    chk("restart_beat", int'(ibeatNum), 0);
    chk("restart_playing", int'(playing), 1);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // Empty song from IDLE.
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("empty_song_playing", int'(playing), 0);

`ifdef MUSIC_LOOP_EN
    loop_lvl = 1'b1;
    cycle(1'b1, 2'd2, 1'b0, 1'b0, loop_lvl);
    run_to_beat(47, 300);
    n = 0; nd = 0; nm = 0;
    while (ibeatNum != 12'd0 && n < 10) begin
      cycle(1'b0, 2'd0, 1'b0, 1'b0, loop_lvl);
      n++;
      if (done) nd++;
      if (mute) nm++;
    end
    chk("loop_wrap_delay", n, DIV);
    chk("loop_no_done", nd, 0);
    chk("loop_no_mute", nm, 0);
    loop_lvl = 1'b0;
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
`endif

    // Random traffic against the model.
    pz = 1'b0; lp = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!pz && $urandom_range(0, 39) == 0) pz = 1'b1;
      else if (pz && $urandom_range(0, 7) == 0) pz = 1'b0;
      if ($urandom_range(0, 99) == 0) lp = ~lp;
      cycle(($urandom_range(0, 149) == 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 499) == 0), pz, lp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
